// File: rtl/cla_add_sequencer.sv
// Sequential WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead slice,
// walking the operands one nibble per cycle from the least-significant end.
module cla_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [WIDTH-1:0] a_reg, b_reg, sum_nxt;
  logic [3:0]      x, y, g, p, s_nib;
  logic [4:0]      c;
  logic            last;

  assign last      = (idx == IDXW'(NIB - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    x = '0;
    y = '0;
    for (int n = 0; n < NIB; n++) begin
      if (idx == IDXW'(n)) begin
        x = a_reg[4*n +: 4];
        y = b_reg[4*n +: 4];
      end
    end
  end

  // Two-level lookahead: every carry is a flat sum of products from the nibble carry-in.
  assign g = x & y;
  assign p = x | y;
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & carry);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry);
  assign s_nib = x ^ y ^ c[3:0];

  always_comb begin
    sum_nxt = sum;
    for (int n = 0; n < NIB; n++) begin
      if (idx == IDXW'(n)) sum_nxt[4*n +: 4] = s_nib;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Subtraction is folded in at capture time: invert B and force the first carry-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b ^ {WIDTH{sub}};
            carry <= sub | cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum   <= sum_nxt;
          carry <= c[4];
          if (last) begin
            idx  <= '0;
            cout <= c[4];
            ovf  <= c[3] ^ c[4];
            zero <= (sum_nxt == '0);
          end else begin
            idx  <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Bench for cla_add_sequencer: directed vectors with literal results plus an
// arithmetic reference model compared against the DUT every cycle.
module tb_cla_add_sequencer;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  cla_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on accept, a fixed NIB-cycle latency, then hold until taken.
  logic         m_idle = 1'b1;
  logic         m_done = 1'b0;
  int           m_wait = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;
  logic [W-1:0] m_bx;
  logic [W:0]   m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1;
      m_done = 1'b0;
      m_wait = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_bx   = sub ? ~b : b;
        m_full = {1'b0, a} + {1'b0, m_bx} + {{W{1'b0}}, (sub | cin)};
        m_sum  = m_full[W-1:0];
        m_cout = m_full[W];
        m_ovf  = (a[W-1] == m_bx[W-1]) && (m_sum[W-1] != a[W-1]);
        m_zero = (m_sum == '0);
        m_idle = 1'b0;
        m_wait = NIB;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_done = 1'b1;
    end else if (m_done && out_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("model in_ready", in_ready, m_idle);
    check("model out_valid", out_valid, m_done);
    if (m_done) begin
      check("model sum", sum, m_sum);
      check("model cout", cout, m_cout);
      check("model ovf", ovf, m_ovf);
      check("model zero", zero, m_zero);
    end
  end

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic ts, input logic tc);
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("accept", in_ready, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] es, input logic ec,
                             input logic eo, input logic ez, input int hold);
    int cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " latency"}, cyc, NIB);
    check({name, " sum"}, sum, es);
    check({name, " cout"}, cout, ec);
    check({name, " ovf"}, ovf, eo);
    check({name, " zero"}, zero, ez);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = W'($urandom());
      b = W'($urandom());
      @(posedge clk);
      #1;
      check({name, " held sum"}, sum, es);
      check({name, " held ovf"}, ovf, eo);
      check({name, " held in_ready"}, in_ready, 1'b0);
      check({name, " held out_valid"}, out_valid, 1'b1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = (hold > 0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    check({name, " handshake in_ready"}, in_ready, 1'b1);
    check({name, " handshake out_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    #3;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset sum", sum, 16'h0000);
    check("reset zero", zero, 1'b0);

    // Request already pending when reset releases must be taken at the very next edge.
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("first accept", in_ready, 1'b0);
    checkOutput("add 00FF+1", 16'h0100, 1'b0, 1'b0, 1'b0, 0);

    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add FFFF+1", 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add 7FFF+1", 16'h8000, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b1);
    checkOutput("add cin", 16'h2346, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
    checkOutput("sub 5-7", 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(16'h1234, 16'h1234, 1'b1, 1'b0);
    checkOutput("sub equal", 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0);
    checkOutput("sub backpressure", 16'h7FFF, 1'b1, 1'b1, 1'b0, 3);

    // Abort an operation two nibbles in; outputs must clear without a clock edge.
    applyStimulus(16'h1111, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun reset in_ready", in_ready, 1'b1);
    check("midrun reset out_valid", out_valid, 1'b0);
    check("midrun reset sum", sum, 16'h0000);
    check("midrun reset cout", cout, 1'b0);
    check("midrun reset ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check("post reset out_valid", out_valid, 1'b0);
    end
    check("post reset in_ready", in_ready, 1'b1);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      cin       = 1'($urandom_range(0, 1));
      a         = W'($urandom());
      b         = W'($urandom());
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (NIB + 4) @(posedge clk);
    #1 check("drain in_ready", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
